fifo_rd_fwft: RTL and testbench

//  Read-side output stage of the async FIFO, in the rclk domain, downstream of the read-pointer handler.
//  - Consumes the handler's registered empty flag and the dual-port RAM's registered read data.
//  - Drives the handler's r_en.
//  - Presents a first-word-fall-through valid/ready stream to the consumer, e.g. the DDR write-data path.
//  - Hides RAM read latency with a small skid buffer, so it sustains 1 word/cycle while the FIFO is non-empty.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_skid_buf.sv | 66 ++++++
 rtl/fifo_rd_fwft.sv | 79 +++++++
 tb/tb_fifo_rd_fwft.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared parameters and sizing helpers for the async FIFO read side.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned MEM_RD_LAT_MIN  = 1;
  localparam int unsigned MEM_RD_LAT_MAX  = 2;

  // The skid buffer covers every read still in the RAM pipeline plus the word on the output.
  function automatic int unsigned skid_depth(input int unsigned rd_lat);
    return rd_lat + 1;
  endfunction

  // Bits needed to count 0..depth entries.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular buffer with push/pop and an occupancy count.
// The output word is read straight from storage, so it is fully registered.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LVL_W      = level_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [LVL_W-1:0]      o_level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage: write at the write pointer; cleared on reset so the output reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap modulo DEPTH; level tracks push minus pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: ;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // A push into a full buffer means the issue logic overran its slot budget.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && (r_level == LVL_W'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_pop && (r_level == '0)));

endmodule

// File: rtl/fifo_rd_fwft.sv
// Read-side FWFT output stage of the async FIFO (rclk domain).
// Issues reads to the pointer handler/RAM, tracks reads in flight through the
// RAM pipeline, and lands returned words in a skid buffer that feeds a
// valid/ready stream at one word per cycle.
module fifo_rd_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            buf_level
);

  localparam int unsigned BUF_DEPTH = skid_depth(MEM_RD_LAT);
  localparam int unsigned LVL_W     = level_width(BUF_DEPTH);
  localparam int unsigned OCC_W     = LVL_W + 1;

  logic                  r_run;
  logic [MEM_RD_LAT-1:0] r_inflight;
  logic                  w_rd_acc;
  logic                  w_push;
  logic                  w_pop;
  logic [LVL_W-1:0]      w_level;
  logic [OCC_W-1:0]      w_occ;

  assign w_rd_acc  = r_en & ~empty;
  assign w_push    = r_inflight[MEM_RD_LAT-1];
  assign m_valid   = (w_level != '0);
  assign w_pop     = m_valid & m_ready;
  assign buf_level = 2'(w_level);

  // Hold off reads until the first rclk edge after reset release.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) r_run <= 1'b0;
    else         r_run <= 1'b1;
  end

  // Issue a read only when the word it fetches is guaranteed a buffer slot on arrival.
  always_comb begin
    w_occ = OCC_W'(w_level) + OCC_W'($countones(r_inflight)) - OCC_W'(w_pop);
    r_en  = r_run & ~empty & (w_occ < OCC_W'(BUF_DEPTH));
  end

  // Each accepted read rides this shift register until its data is valid on mem_rdata.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_inflight <= '0;
    end else begin
      r_inflight[0] <= w_rd_acc;
      for (int unsigned i = 1; i < MEM_RD_LAT; i++) r_inflight[i] <= r_inflight[i-1];
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH),
    .LVL_W      (LVL_W)
  ) u_skid_buf (
    .clk     (rclk),
    .rst_n   (rrst_n),
    .i_push  (w_push),
    .i_wdata (mem_rdata),
    .i_pop   (w_pop),
    .o_rdata (m_data),
    .o_level (w_level)
  );

  a_lat_legal: assert property (@(posedge rclk)
    (MEM_RD_LAT >= MEM_RD_LAT_MIN) && (MEM_RD_LAT <= MEM_RD_LAT_MAX));

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: one instance per legal read latency, each fed by a
// behavioural handler/RAM model and checked against a word-level scoreboard.
module tb_fifo_rd_fwft;

  localparam int unsigned DW = 8;
  localparam int unsigned NI = 2;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
  } ent_t;

  logic          rclk    = 1'b0;
  logic          rrst_n  = 1'b0;
  logic          m_ready = 1'b0;
  logic          empty     [NI];
  logic [DW-1:0] mem_rdata [NI];
  logic          r_en      [NI];
  logic          m_valid   [NI];
  logic [DW-1:0] m_data    [NI];
  logic [1:0]    buf_level [NI];

  fifo_rd_fwft #(.DATA_WIDTH(DW), .MEM_RD_LAT(1)) u_dut_l1 (
    .rclk(rclk), .rrst_n(rrst_n), .empty(empty[0]), .mem_rdata(mem_rdata[0]),
    .r_en(r_en[0]), .m_valid(m_valid[0]), .m_data(m_data[0]),
    .m_ready(m_ready), .buf_level(buf_level[0])
  );

  fifo_rd_fwft #(.DATA_WIDTH(DW), .MEM_RD_LAT(2)) u_dut_l2 (
    .rclk(rclk), .rrst_n(rrst_n), .empty(empty[1]), .mem_rdata(mem_rdata[1]),
    .r_en(r_en[1]), .m_valid(m_valid[1]), .m_data(m_data[1]),
    .m_ready(m_ready), .buf_level(buf_level[1])
  );

  always #5 rclk = ~rclk;

  // Reference model state per instance:
  //   src   : words still held in the FIFO RAM (empty = none left)
  //   pipe  : accepted reads, due on mem_rdata at cycle T+lat
  //   sb    : accepted, undelivered words; deliverable from cycle T+lat+1
  logic [DW-1:0] src  [NI][$];
  ent_t          pipe [NI][$];
  ent_t          sb   [NI][$];
  int unsigned   lat  [NI] = '{1, 2};
  bit            run;
  int unsigned   cyc;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic string tg(input string name, input int k);
    return $sformatf("%s[L%0d]@%0d", name, lat[k], cyc);
  endfunction

  // One rclk cycle: drive handler/RAM inputs, check at negedge, advance model.
  task automatic cycle();
    int  lvl;
    bit  vexp, pexp, rexp;
    logic [DW-1:0] w;
    for (int k = 0; k < NI; k++) begin
      empty[k] = (src[k].size() == 0);
      if (pipe[k].size() != 0 && pipe[k][0].cyc == cyc) begin
        mem_rdata[k] = pipe[k][0].data;
        void'(pipe[k].pop_front());
      end else begin
        mem_rdata[k] = DW'($urandom);
      end
    end
    @(negedge rclk);
    for (int k = 0; k < NI; k++) begin
      lvl = 0;
      for (int i = 0; i < sb[k].size(); i++) if (sb[k][i].cyc <= cyc) lvl++;
      vexp = (lvl != 0);
      pexp = vexp && m_ready;
      rexp = run && (src[k].size() != 0) &&
             ((int'(sb[k].size()) - int'(pexp)) < int'(lat[k] + 1));
      check(tg("r_en", k), 32'(r_en[k]), 32'(rexp));
      check(tg("m_valid", k), 32'(m_valid[k]), 32'(vexp));
      check(tg("buf_level", k), 32'(buf_level[k]), 32'(lvl));
      if (vexp) check(tg("m_data", k), 32'(m_data[k]), 32'(sb[k][0].data));
      if (pexp) void'(sb[k].pop_front());
      if (rexp) begin
        w = src[k].pop_front();
        sb[k].push_back('{cyc: cyc + lat[k] + 1, data: w});
        pipe[k].push_back('{cyc: cyc + lat[k], data: w});
      end
    end
    @(posedge rclk);
    cyc++;
    if (rrst_n) run = 1'b1;
    #1;
  endtask

  task automatic fill_seq(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < NI; k++) src[k].push_back(base + DW'(i));
  endtask

  task automatic fill_rand(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom);
      for (int k = 0; k < NI; k++) src[k].push_back(w);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    run      = 1'b0;
    for (int k = 0; k < NI; k++) begin
      empty[k]     = 1'b1;
      mem_rdata[k] = '0;
    end
    @(posedge rclk);
    #1;

    // Reset held with words available: no reads, nothing valid.
    fill_seq(16, 8'h00);
    repeat (3) cycle();
    for (int k = 0; k < NI; k++) check(tg("rst_m_data", k), 32'(m_data[k]), 32'h0);

    // Release and stream 0x00..0x0F with the consumer always ready.
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    repeat (24) cycle();

    // Backpressure: buffer fills to its depth and holds the first word.
    fill_seq(16, 8'h00);
    m_ready = 1'b0;
    repeat (10) cycle();
    for (int k = 0; k < NI; k++) begin
      check(tg("bp_level", k), 32'(buf_level[k]), 32'(lat[k] + 1));
      check(tg("bp_data", k), 32'(m_data[k]), 32'h00);
    end
    m_ready = 1'b1;
    repeat (25) cycle();

    // Single word; empty rises the cycle after it is read.
    src[0].push_back(8'hA5);
    src[1].push_back(8'hA5);
    repeat (8) cycle();

    // Alternating consumer readiness over 20 words.
    fill_rand(20);
    for (int i = 0; i < 50; i++) begin
      m_ready = ((i % 2) == 0);
      cycle();
    end
    m_ready = 1'b1;
    repeat (6) cycle();

    // Random refills and random readiness.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) fill_rand(int'($urandom_range(1, 6)));
      m_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    m_ready = 1'b1;
    repeat (40) cycle();

    // Mid-stream reset with words buffered: discarded at once.
    fill_seq(10, 8'h40);
    m_ready = 1'b0;
    repeat (6) cycle();
    check(tg("pre_rst_level", 0), 32'(buf_level[0]), 32'd2);
    rrst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check(tg("mid_rst_valid", k), 32'(m_valid[k]), 32'h0);
      check(tg("mid_rst_level", k), 32'(buf_level[k]), 32'h0);
      check(tg("mid_rst_r_en", k), 32'(r_en[k]), 32'h0);
      sb[k].delete();
      pipe[k].delete();
    end
    run = 1'b0;
    repeat (2) cycle();
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    repeat (30) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
